// File: rtl/result_collector_pkg.sv
// Shared definitions for the result collector: FSM encoding, slot count
// and the unsigned 8-bit saturation bound.
package result_collector_pkg;

  localparam int N_SLOTS = 8;
  localparam int SAT_MAX = 255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/sat_u8.sv
// Clamps a signed result word into 0..SAT_MAX for the display; flags only
// words clamped from above (negatives simply floor to zero).
module sat_u8 #(
  parameter int IN_W = 16
) (
  input  logic signed [IN_W-1:0] din,
  output logic        [7:0]      dout,
  output logic                   clamp
);
  import result_collector_pkg::*;

  localparam logic signed [IN_W-1:0] MAX_W = IN_W'(SAT_MAX);

  always_comb begin
    dout  = '0;
    clamp = 1'b0;
    if (din[IN_W-1]) begin
      dout = '0;
    end else if (din > MAX_W) begin
      dout  = 8'(SAT_MAX);
      clamp = 1'b1;
    end else begin
      dout = din[7:0];
    end
  end

endmodule

// File: rtl/result_collector.sv
// Collects eight saturated convolution results per frame into named display slots.
//   state      | meaning
//   ST_IDLE    | after reset, waiting for start
//   ST_COLLECT | in_ready high, slot[count] written on each transfer
//   ST_DONE    | all slots filled, values held until the next start
module result_collector #(
  parameter int IN_W    = 16,
  parameter int N_SLOTS = result_collector_pkg::N_SLOTS
) (
  input  logic            clk_1hz,
  input  logic            resetn,
  input  logic            start,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  output logic            in_ready,
  output logic [7:0]      c9_11,
  output logic [7:0]      c9_12,
  output logic [7:0]      c9_21,
  output logic [7:0]      c9_22,
  output logic [7:0]      c4_11,
  output logic [7:0]      c4_12,
  output logic [7:0]      c4_21,
  output logic [7:0]      c4_22,
  output logic [3:0]      count,
  output logic            done,
  output logic            sat
);
  import result_collector_pkg::*;

  state_e     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       sat_q, sat_d;
  logic [7:0] slots_q [N_SLOTS];
  logic [7:0] slots_d [N_SLOTS];

  logic [7:0] sat_val;
  logic       sat_clamp;

  sat_u8 #(.IN_W(IN_W)) u_sat (
    .din   (in_data),
    .dout  (sat_val),
    .clamp (sat_clamp)
  );

  always_ff @(posedge clk_1hz or posedge resetn) begin
    if (resetn) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      sat_q   <= 1'b0;
      slots_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sat_q   <= sat_d;
      slots_q <= slots_d;
    end
  end

  // start wins over a word on the same edge, in every state
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sat_d   = sat_q;
    slots_d = slots_q;
    if (start) begin
      state_d = ST_COLLECT;
      count_d = '0;
      sat_d   = 1'b0;
      slots_d = '{default: '0};
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (in_valid) begin
            slots_d[count_q[2:0]] = sat_val;
            sat_d   = sat_q | sat_clamp;
            count_d = count_q + 4'd1;
            if (count_q == 4'(N_SLOTS - 1)) state_d = ST_DONE;
          end
        end
        ST_IDLE, ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == ST_COLLECT);
  assign done     = (state_q == ST_DONE);
  assign count    = count_q;
  assign sat      = sat_q;

  assign c9_11 = slots_q[0];
  assign c9_12 = slots_q[1];
  assign c9_21 = slots_q[2];
  assign c9_22 = slots_q[3];
  assign c4_11 = slots_q[4];
  assign c4_12 = slots_q[5];
  assign c4_21 = slots_q[6];
  assign c4_22 = slots_q[7];

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameter IN_W, default 16, width of the signed result word from the convolution engine.
REQ-002 Parameter N_SLOTS, default 8, number of result slots; fixed at 8 for this block.
REQ-003 clk_1hz  input  1  step clock; all state changes on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle pulse; clears the slots and begins a new frame.
REQ-006 in_valid  input  1  producer has a word on in_data.
REQ-007 in_data  input  IN_W  signed two's-complement result word.
REQ-008 in_ready  output  1  collector accepts a word this cycle.
REQ-009 c9_11, c9_12, c9_21, c9_22  output  8 each  3x3-kernel results in 0..255, for the display.
REQ-010 c4_11, c4_12, c4_21, c4_22  output  8 each  2x2-kernel results in 0..255, for the display.
REQ-011 count  output  4  number of slots filled in the current frame, 0..8.
REQ-012 done  output  1  all 8 slots filled; values are stable.
REQ-013 sat  output  1  sticky flag; at least one word in this frame was clamped.

Function
REQ-014 The FSM SHALL have three states: IDLE, COLLECT and DONE.
REQ-015 in_ready SHALL be 1 exactly when the state is COLLECT (Moore output, no combinational path from in_valid).
REQ-016 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1, with start=0.
REQ-017 On a transfer, the block SHALL write the saturated word into the slot indexed by count and increment count.
REQ-018 Slot order SHALL be c9_11, c9_12, c9_21, c9_22, c4_11, c4_12, c4_21, c4_22 (index 0..7).
REQ-019 Saturation: in_data<0 SHALL store 0; in_data>255 SHALL store 255 and set sat; otherwise the block SHALL store in_data[7:0].
REQ-020 Latency: the stored value SHALL be visible on its output port immediately after the accepting edge.
REQ-021 IDLE: start=1 SHALL zero all slots, count and sat, and move to COLLECT; in_valid SHALL be ignored.
REQ-022 COLLECT: the 8th transfer SHALL move to DONE; done=1 and in_ready=0 from the following cycle.
REQ-023 DONE: slots, count=8 and sat SHALL hold; in_valid SHALL be ignored.
REQ-024 DONE: start=1 SHALL clear as in REQ-021, set done=0 and move to COLLECT.
REQ-025 start=1 in COLLECT SHALL abandon the partial frame, clear as in REQ-021 and remain in COLLECT.
REQ-026 A word presented on the same edge as start (REQ-025) SHALL NOT be stored.
REQ-027 count SHALL never exceed 8 and SHALL NOT wrap.
REQ-028 Slots beyond count SHALL read 0 during COLLECT.

Reset
REQ-029 resetn=1 SHALL immediately force state=IDLE, all slots=0, count=0, done=0, sat=0 and in_ready=0, regardless of clock.
REQ-030 Reset asserted mid-frame SHALL discard all partial data.
REQ-031 After release, the block SHALL wait in IDLE for start.

Structure
REQ-032 The state encoding (IDLE/COLLECT/DONE), N_SLOTS=8 and the saturation bound 255 SHALL live in the shared project package.
REQ-033 Saturation SHALL be a separate combinational sub-module, sat_u8 (IN_W signed in, 8-bit value plus clamp flag out).
REQ-034 The slots SHALL be a register file indexed by count and fanned out to the eight named ports.

Verification
REQ-035 Reset, start, then values 1..8 with in_valid held high: c9_11=1 … c4_22=8; done=1 after the 8th edge; count=8; sat=0.
REQ-036 Saturation: words -5, 300, 255, 0, 1000, 12, -1, 256 must store 0, 255, 255, 0, 255, 12, 0, 255, with sat=1.
REQ-037 Backpressure gaps: in_valid low for 3 cycles between words; count advances only on valid edges; final values are unchanged.
REQ-038 Restart mid-frame: after 5 words, assert start with in_valid=1 and data=99; count=0, all slots 0, and 99 is not stored.
REQ-039 DONE hold: in_valid=1 with data=77 for 4 cycles; slots and count=8 are unchanged; a later start gives done=0 and count=0.
REQ-040 Async reset mid-frame between clock edges: all outputs 0 immediately; state=IDLE; in_ready=0.
